// File: rtl/mul_acc_stage.sv
// Accumulates signed products from the Booth multiplier into one wide sum per burst.
// Optional output clamping to the signed product range is enabled by defining MUL_ACC_SAT_EN.
module mul_acc_stage #(
  parameter int unsigned PROD_W = 64,
  parameter int unsigned ACC_W  = 80,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              ovf,
  output logic              sat
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_out_q;
  logic             ovf_out_q;
  logic             sat_q;

  logic             beat;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] count_inc;
  logic             ovf_inc;
  logic [ACC_W-1:0] res_sum;
  logic             res_sat;

  always_comb begin
    in_ready  = (state_q == ST_ACCUM) && !clr;
    beat      = in_valid && in_ready;
    prod_ext  = {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product};
    acc_sum   = acc_q + prod_ext;
    // A beat arriving when the count is already saturated marks the burst as overlong.
    count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    ovf_inc   = ovf_q | (count_q == CNT_MAX);
  end

`ifdef MUL_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W-PROD_W+1){1'b0}}, {(PROD_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {{(ACC_W-PROD_W+1){1'b1}}, {(PROD_W-1){1'b0}}};

  logic [ACC_W-PROD_W:0] hi_bits;

  // The sum fits the product range when every bit above the product sign bit matches it.
  always_comb begin
    hi_bits = acc_sum[ACC_W-1:PROD_W-1];
    res_sat = !((&hi_bits) || !(|hi_bits));
    if (!res_sat) begin
      res_sum = acc_sum;
    end else if (acc_sum[ACC_W-1]) begin
      res_sum = SUM_MIN;
    end else begin
      res_sum = SUM_MAX;
    end
  end
`else
  always_comb begin
    res_sum = acc_sum;
    res_sat = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      cnt_out_q <= '0;
      ovf_out_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if (clr) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            if (in_last) begin
              sum_q     <= res_sum;
              cnt_out_q <= count_inc;
              ovf_out_q <= ovf_inc;
              sat_q     <= res_sat;
              acc_q     <= '0;
              count_q   <= '0;
              ovf_q     <= 1'b0;
              state_q   <= ST_HOLD;
            end else begin
              acc_q   <= acc_sum;
              count_q <= count_inc;
              ovf_q   <= ovf_inc;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q <= ST_ACCUM;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = sum_q;
  assign out_count = cnt_out_q;
  assign ovf       = ovf_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Randomized scoreboard bench for mul_acc_stage; expected results come from a plain arithmetic
// model of each burst. Build with MUL_ACC_SAT_EN defined to exercise output clamping.
module tb_mul_acc_stage;

  localparam int unsigned PROD_W = 64;
  localparam int unsigned ACC_W  = 80;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             sat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              ovf;
  logic              sat;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  exp_t exp_q[$];

  logic signed [ACC_W-1:0] m_sum;
  int                      m_beats;

  mul_acc_stage #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .ovf        (ovf),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: sum of the burst's signed products, wrapped to ACC_W; count saturates at 255.
  task automatic model_accept(input logic [PROD_W-1:0] p, input bit last);
    logic signed [PROD_W-1:0] ps;
    logic signed [ACC_W-1:0]  lim_hi;
    logic signed [ACC_W-1:0]  lim_lo;
    exp_t e;
    ps = p;
    m_sum = m_sum + ps;
    m_beats++;
    if (last) begin
      lim_hi = (ACC_W'(1) <<< (PROD_W - 1)) - 1;
      lim_lo = -(ACC_W'(1) <<< (PROD_W - 1));
      e.sum = m_sum;
      e.sat = 1'b0;
`ifdef MUL_ACC_SAT_EN
      if (m_sum > lim_hi) begin
        e.sum = lim_hi;
        e.sat = 1'b1;
      end else if (m_sum < lim_lo) begin
        e.sum = lim_lo;
        e.sat = 1'b1;
      end
`endif
      e.cnt = (m_beats > 255) ? 8'd255 : CNT_W'(m_beats);
      e.ovf = (m_beats > 255);
      exp_q.push_back(e);
      m_sum   = '0;
      m_beats = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge (or the
  // following falling edge for a last beat, where the 1-cycle latency is checked).
  task automatic send_beat(input logic [PROD_W-1:0] p, input bit last);
    int waitc = 0;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    @(negedge clk);
    while (!in_ready && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("beat_accept_timeout", 80'(in_ready), 80'(1));
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    model_accept(p, last);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last) begin
      @(negedge clk);
      check("result_latency", 80'(out_valid), 80'(1));
    end
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    check("drain_pending", 80'(exp_q.size()), 80'(0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: any presented result must equal the oldest expected one, every cycle it is held.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 80'(out_valid), 80'(0));
      end else begin
        check("out_sum", out_sum, exp_q[0].sum);
        check("out_count", 80'(out_count), 80'(exp_q[0].cnt));
        check("ovf", 80'(ovf), 80'(exp_q[0].ovf));
        check("sat", 80'(sat), 80'(exp_q[0].sat));
        check("in_ready_in_hold", 80'(in_ready), 80'(0));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [PROD_W-1:0] pmax;
    logic [PROD_W-1:0] p;
    pmax       = {1'b0, {(PROD_W-1){1'b1}}};
    rst        = 1'b1;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    m_sum      = '0;
    m_beats    = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_out_sum", out_sum, 80'(0));
    check("rst_out_count", 80'(out_count), 80'(0));
    check("rst_ovf", 80'(ovf), 80'(0));
    check("rst_sat", 80'(sat), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(1));
    @(posedge clk);
    #1;

    // 3-beat burst, then hold the result under back-pressure.
    ready_mode = 2;
    send_beat(64'd5, 1'b0);
    send_beat(-64'sd2, 1'b0);
    send_beat(64'd10, 1'b1);
    check("burst3_sum_const", out_sum, 80'd13);
    repeat (4) begin
      @(negedge clk);
      check("hold_in_ready", 80'(in_ready), 80'(0));
    end
    ready_mode = 0;
    drain();

    send_beat(pmax, 1'b1);
    drain();
    send_beat(pmax, 1'b0);
    send_beat(pmax, 1'b1);
    drain();

    // Overlong burst, then a short one to show ovf is per burst.
    for (int i = 0; i < 300; i++) send_beat(64'd1, i == 299);
    drain();
    send_beat(64'd4, 1'b1);
    drain();

    // Flush mid-burst with a beat presented alongside clr.
    send_beat(64'd100, 1'b0);
    send_beat(64'd200, 1'b0);
    clr        = 1'b1;
    in_valid   = 1'b1;
    in_product = 64'd55;
    in_last    = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 80'(in_ready), 80'(0));
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    m_sum    = '0;
    m_beats  = 0;
    send_beat(64'd7, 1'b1);
    drain();

    // Random traffic with back-pressure.
    ready_mode = 1;
    for (int b = 0; b < 1000; b++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        case ($urandom_range(0, 3))
          0:       p = {$urandom, $urandom};
          1:       p = 64'($signed(16'($urandom)));
          2:       p = pmax;
          default: p = ~pmax;
        endcase
        send_beat(p, i == len - 1);
      end
    end
    drain();

    // Reset while a result is held.
    ready_mode = 2;
    send_beat(64'd3, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_hold_out_valid", 80'(out_valid), 80'(0));
    check("rst_in_hold_out_sum", out_sum, 80'(0));
    exp_q.delete();
    rst = 1'b0;
    ready_mode = 0;
    send_beat(64'd9, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
